// File: rtl/cla_seq_adder_pkg.sv
// Shared slice width, FSM encoding and index sizing helper for the sequential CLA adder.
package cla_seq_adder_pkg;

  localparam int SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk index width; a single-chunk adder still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_seq_adder_cla8bits.sv
// 8-bit carry-lookahead slice with group generate/propagate; purely combinational,
// zero latency, no flow control.
module cla8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       g,
  output logic       p
);

  logic [7:0] gi;
  logic [7:0] pi;
  logic [8:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  // Each carry is a flat sum-of-products over lower generates, not a ripple chain.
  always_comb begin
    logic acc;
    logic run;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (gi[j] & run);
        run = run & pi[j];
      end
      c[i+1] = acc | (run & cin);
    end
  end

  always_comb begin
    logic run;
    g   = 1'b0;
    run = 1'b1;
    for (int j = 7; j >= 0; j--) begin
      g   = g | (gi[j] & run);
      run = run & pi[j];
    end
  end

  assign p    = &pi;
  assign sum  = pi ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder time-sharing one cla8bits slice, LS chunk first; result valid WIDTH/8+1
// cycles after accept, held in DONE until out_ready, no new accept until back in IDLE.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             gen,
  output logic             prop,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic             gen_acc;
  logic             prop_acc;

  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic             s_g;
  logic             s_p;
  logic             gen_next;
  logic             prop_next;

  cla8bits u_slice (
    .a    (a_reg[idx*SLICE +: SLICE]),
    .b    (b_reg[idx*SLICE +: SLICE]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout),
    .g    (s_g),
    .p    (s_p)
  );

  // Group G/P of the chunks seen so far, with the current chunk as the MS group.
  assign gen_next  = s_g | (s_p & gen_acc);
  assign prop_next = s_p & prop_acc;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      gen_acc   <= 1'b0;
      prop_acc  <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      gen       <= 1'b0;
      prop      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= cin;
            idx      <= '0;
            prop_acc <= 1'b1;
            gen_acc  <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[idx*SLICE +: SLICE] <= s_sum;
          carry    <= s_cout;
          gen_acc  <= gen_next;
          prop_acc <= prop_next;
          idx      <= idx + 1'b1;
          if (idx == LAST) begin
            cout      <= s_cout;
            gen       <= gen_next;
            prop      <= prop_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder (WIDTH=32): directed vector table, multi-cycle corner sequences
// and random operations against an arithmetic reference model.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        gen;
  logic        prop;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  cla_seq_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .gen       (gen),
    .prop      (prop),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        g;
    logic        p;
  } vec_t;

  vec_t tbl[8];

  // Reference: {gen, prop, cout, sum}. Group generate is the carry out of a+b with no
  // carry-in; group propagate means every bit position propagates.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] t;
    logic [32:0] g33;
    t   = {1'b0, x} + {1'b0, y} + {32'd0, c};
    g33 = {1'b0, x} + {1'b0, y};
    return {g33[32], ((x ^ y) == 32'hFFFF_FFFF), t};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_out(input string nm, output int k);
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  // Enters and leaves at a negedge; checks latency, result, hold under backpressure.
  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic tc, input logic [31:0] es, input logic eco,
                        input logic eg, input logic ep, input int hold);
    int  k;
    bit  ok;
    a = ta; b = tbv; cin = tc; in_valid = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 20 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    if (!ok) chk({nm, "_accept"}, 64'(in_ready), 64'd1);
    wait_out(nm, k);
    chk({nm, "_lat"}, 64'(k), 64'd5);
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(eco));
    chk({nm, "_gen"}, 64'(gen), 64'(eg));
    chk({nm, "_prop"}, 64'(prop), 64'(ep));
    for (int h = 0; h < hold; h++) @(negedge clk);
    if (hold > 0) begin
      chk({nm, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({nm, "_hold_sum"}, 64'(sum), 64'(es));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int          k;
    int          t1;
    int          t2;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [34:0] m;

    tbl[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", {61'd0, cout, gen, prop}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
             tbl[i].s, tbl[i].co, tbl[i].g, tbl[i].p, i % 3);

    // Backpressure in DONE with a new request pending
    a = 32'h1; b = 32'h2; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h5; b = 32'h6;
    wait_out("bp", k);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_vld%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_sum%0d", i), 64'(sum), 64'h3);
      chk($sformatf("bp_rdy%0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rdy_after", 64'(in_ready), 64'd1);
    chk("bp_vld_after", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept", 64'(busy), 64'd1);
    wait_out("bp2", k);
    chk("bp2_lat", 64'(k), 64'd5);
    chk("bp2_sum", 64'(sum), 64'hB);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the second RUN cycle
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_busy_before", 64'(busy), 64'd1);
    chk("mrst_sum_partial", 64'(sum), 64'h33);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_sum", 64'(sum), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_no_vld", 64'(out_valid), 64'd0);
    run_op("post_rst", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0);

    // Back-to-back with out_ready tied high and in_valid held
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_accept", 64'(busy), 64'd1);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001;
    wait_out("b2b1", k);
    t1 = cyc;
    chk("b2b1_sum", 64'(sum), 64'h2345_6789);
    chk("b2b1_cout", 64'(cout), 64'd0);
    @(negedge clk);
    wait_out("b2b2", k);
    t2 = cyc;
    in_valid = 1'b0;
    chk("b2b2_sum", 64'(sum), 64'h0);
    chk("b2b2_cout", 64'(cout), 64'd1);
    chk("b2b2_gen", 64'(gen), 64'd1);
    chk("b2b_spacing", 64'(t2 - t1), 64'd6);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", 64'(in_ready), 64'd1);

    // Random operations, some with heavy propagate chains
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? ~ra : $urandom;
      if (i % 5 == 4) rb = rb ^ (32'h1 << $urandom_range(0, 31));
      rc = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rc);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, m[31:0], m[32], m[34], m[33],
             $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
